keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
Scan sequencer for the 4x3 matrix keypad on the GPIO header.
- Drives one row low at a time and samples the three column inputs.
- Debounces across whole scan frames.
- Emits a single-cycle key_press strobe with a 4-bit key_value, consumed by the top-level state machine, the passcode circuit and the puzzle circuit.

Parameters:
SCAN_DIV, 50000, clock cycles each row is driven (dwell); 1 ms at 50 MHz; must be >= 4.
DEBOUNCE_SCANS, 10, consecutive identical frames needed to accept a press or a release; must be >= 2.

Ports:
CLOCK_50  input  1  system clock; all logic on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
scan_en  input  1  1 = scanning active; 0 = scanning halted.
col_n  input  3  keypad columns; active-low; externally pulled up; asynchronous to CLOCK_50.
row_n  output  4  keypad rows; active-low; at most one bit low at a time.
key_press  output  1  one-cycle strobe on each accepted press.
key_value  output  4  code of the last accepted key; held between presses.
key_held  output  1  1 while an accepted key has not yet been released.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - row_n=4'b1111, key_press=0, key_value=0, key_held=0.
  - Row index=0, dwell counter=0, debounce counter=0, FSM=IDLE.
- Column sync: col_n passes through a 2-flop synchronizer before use.
- Row drive:
  - Row r is driven low (row_n = ~(1<<r)) for SCAN_DIV cycles, r = 0,1,2,3, then wraps to 0.
  - The first row is driven low on the first clock after rst_n deasserts while scan_en=1.
- Sampling: synchronized columns are captured on the last dwell cycle of each row; this leaves settling time plus synchronizer latency.
- Key map (row,col -> code):
  - (0,0)=1, (0,1)=2, (0,2)=3
  - (1,0)=4, (1,1)=5, (1,2)=6
  - (2,0)=7, (2,1)=8, (2,2)=9
  - (3,0)=10 (*), (3,1)=0, (3,2)=11 (#)
- Frame result: evaluated after row 3 is sampled; exactly one of:
  - NONE: no column low in any row.
  - SINGLE(code): exactly one key low in the whole frame.
  - MULTI: two or more keys low.
- Debounce counter:
  - Increments, saturating at DEBOUNCE_SCANS, when the frame result equals the previous frame result (code included).
  - Otherwise it loads 1.
  - Any MULTI frame forces it to 0 and is never accepted.
- FSM IDLE -> HELD:
  - Triggered when the result is SINGLE(k) and the counter reaches DEBOUNCE_SCANS.
  - In that same cycle: key_press=1 for exactly one cycle, key_value=k, key_held=1.
- FSM HELD -> IDLE:
  - Triggered when the result is NONE and the counter reaches DEBOUNCE_SCANS; key_held=0.
  - No strobe on release.
  - SINGLE of a different key while in HELD does not strobe; a release must be accepted first.
- Press latency: key_press rises at most (DEBOUNCE_SCANS+1) frames after the contact closes. One frame = 4*SCAN_DIV cycles.
- scan_en=0:
  - Next cycle: row_n=4'b1111; row index, dwell and debounce counters clear; FSM goes to IDLE; key_held=0.
  - No key_press is emitted; key_value is retained.
  - On re-enable, scanning restarts at row 0.
- Reset mid-frame discards all partial-frame data; no strobe is produced.
- key_press never asserts in two consecutive cycles.

Test Plan:
All scenarios use SCAN_DIV=8, DEBOUNCE_SCANS=3 (frame = 32 cycles).
1. Reset, then scan_en=1, no keys -> row_n steps 1110,1101,1011,0111 every 8 cycles and repeats; key_press never asserts; key_value=0.
2. Hold key '5' (col_n[1] low whenever row_n[1]=0), then release -> exactly one key_press within 128 cycles of closure; key_value=5; key_held=1 until 3 NONE frames, then 0.
3. '#' with a 2-frame glitch (closed 40 cycles, open 64, closed steadily) -> a single key_press only after 3 consecutive stable SINGLE(11) frames; key_value=11.
4. Hold '1' and '9' simultaneously for 6 frames -> no key_press. Then release '9' -> key_press with key_value=1 three frames after the last MULTI frame.
5. Hold '0' until key_held=1, then drop scan_en for 10 cycles -> row_n=1111 one cycle later; key_held=0; key_value stays 0. After re-enable with '0' still held, a fresh key_press occurs after 3 frames.
6. Assert rst_n=0 mid-dwell of row 2 with '8' held for 2 frames -> all outputs return to reset values immediately; no strobe is produced; after release of reset, a press requires 3 fresh frames.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// Row-scanning controller for a 4x3 active-low matrix keypad. Whole scan frames are
// debounced, and each accepted press produces a one-cycle strobe carrying the key code.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 10
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       scan_en,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic       key_press,
    output logic [3:0] key_value,
    output logic       key_held
);

    localparam int DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_MAX    = DEB_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} result_t;
    typedef enum logic {ST_IDLE, ST_HELD} state_t;

    // Row 3 holds the irregular keys: * = 10, 0 = 0, # = 11.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = 4'd10;
                2'd1:    code = 4'd0;
                default: code = 4'd11;
            endcase
        end else begin
            code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
        end
        return code;
    endfunction

    logic [2:0]         col_meta_reg;
    logic [2:0]         col_sync_reg;
    logic               running_reg;
    logic [1:0]         row_idx_reg;
    logic [DWELL_W-1:0] dwell_reg;
    logic               sample;

    logic [2:0]         row_keys;
    logic [1:0]         row_cnt;
    logic [1:0]         row_col;
    logic [2:0]         sum_cnt;
    logic [1:0]         tot_cnt;
    logic [3:0]         tot_code;
    result_t            frame_kind;

    logic [1:0]         acc_cnt_reg;
    logic [3:0]         acc_code_reg;
    logic               frame_done_reg;
    result_t            res_kind_reg;
    logic [3:0]         res_code_reg;

    result_t            prev_kind_reg;
    logic [3:0]         prev_code_reg;
    logic [DEB_W-1:0]   deb_reg;
    logic [DEB_W-1:0]   deb_next;
    logic               accepted;

    state_t             state_reg;
    state_t             state_next;
    logic               press_fire;

    logic               key_press_reg;
    logic [3:0]         key_value_reg;
    logic               key_held_reg;

    // Columns are asynchronous to the clock.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_reg <= 3'b111;
            col_sync_reg <= 3'b111;
        end else begin
            col_meta_reg <= col_n;
            col_sync_reg <= col_meta_reg;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            running_reg <= 1'b0;
            row_idx_reg <= 2'd0;
            dwell_reg   <= '0;
        end else if (!scan_en) begin
            running_reg <= 1'b0;
            row_idx_reg <= 2'd0;
            dwell_reg   <= '0;
        end else if (!running_reg) begin
            running_reg <= 1'b1;
        end else if (dwell_reg == DWELL_LAST) begin
            dwell_reg   <= '0;
            row_idx_reg <= row_idx_reg + 2'd1;
        end else begin
            dwell_reg <= dwell_reg + 1'b1;
        end
    end

    assign sample = scan_en && running_reg && (dwell_reg == DWELL_LAST);

    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        assign row_n[gi] = ~(running_reg && (row_idx_reg == 2'(gi)));
    end

    // Fold the current row's columns into the running frame tally.
    always_comb begin
        row_keys = ~col_sync_reg;
        row_cnt  = {1'b0, row_keys[0]} + {1'b0, row_keys[1]} + {1'b0, row_keys[2]};
        if (row_keys[0])      row_col = 2'd0;
        else if (row_keys[1]) row_col = 2'd1;
        else                  row_col = 2'd2;
        sum_cnt  = {1'b0, acc_cnt_reg} + {1'b0, row_cnt};
        tot_cnt  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
        tot_code = (row_cnt == 2'd1) ? key_code(row_idx_reg, row_col) : acc_code_reg;
        case (tot_cnt)
            2'd0:    frame_kind = RES_NONE;
            2'd1:    frame_kind = RES_SINGLE;
            default: frame_kind = RES_MULTI;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_reg    <= 2'd0;
            acc_code_reg   <= 4'd0;
            frame_done_reg <= 1'b0;
            res_kind_reg   <= RES_NONE;
            res_code_reg   <= 4'd0;
        end else begin
            frame_done_reg <= 1'b0;
            if (!scan_en) begin
                acc_cnt_reg  <= 2'd0;
                acc_code_reg <= 4'd0;
            end else if (sample) begin
                if (row_idx_reg == 2'd3) begin
                    acc_cnt_reg    <= 2'd0;
                    acc_code_reg   <= 4'd0;
                    frame_done_reg <= 1'b1;
                    res_kind_reg   <= frame_kind;
                    res_code_reg   <= tot_code;
                end else begin
                    acc_cnt_reg  <= tot_cnt;
                    acc_code_reg <= tot_code;
                end
            end
        end
    end

    // Code only distinguishes results for SINGLE frames.
    always_comb begin
        deb_next = deb_reg;
        if (frame_done_reg) begin
            if (res_kind_reg == RES_MULTI) begin
                deb_next = '0;
            end else if ((res_kind_reg == prev_kind_reg) &&
                         ((res_kind_reg != RES_SINGLE) || (res_code_reg == prev_code_reg))) begin
                deb_next = (deb_reg == DEB_MAX) ? DEB_MAX : deb_reg + 1'b1;
            end else begin
                deb_next = DEB_W'(1);
            end
        end
        accepted = frame_done_reg && (deb_next == DEB_MAX);
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            deb_reg       <= '0;
            prev_kind_reg <= RES_NONE;
            prev_code_reg <= 4'd0;
        end else if (!scan_en) begin
            deb_reg       <= '0;
            prev_kind_reg <= RES_NONE;
            prev_code_reg <= 4'd0;
        end else if (frame_done_reg) begin
            deb_reg       <= deb_next;
            prev_kind_reg <= res_kind_reg;
            prev_code_reg <= res_code_reg;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (!scan_en) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (accepted && (res_kind_reg == RES_SINGLE)) state_next = ST_HELD;
                ST_HELD: if (accepted && (res_kind_reg == RES_NONE))   state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        press_fire = scan_en && (state_reg == ST_IDLE) && accepted && (res_kind_reg == RES_SINGLE);
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            key_press_reg <= 1'b0;
            key_value_reg <= 4'd0;
            key_held_reg  <= 1'b0;
        end else begin
            key_press_reg <= press_fire;
            key_held_reg  <= (state_next == ST_HELD);
            if (press_fire) key_value_reg <= res_code_reg;
        end
    end

    assign key_press = key_press_reg;
    assign key_value = key_value_reg;
    assign key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a keypad model drives the columns, and a
// scoreboard queue holds the expected presses, each with a cycle window, for a strobe monitor.
module tb_keypad_scan_ctrl;

    localparam int SD = 8;
    localparam int DB = 3;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       scan_en = 1'b0;
    logic [2:0] col_n;
    logic [3:0] row_n;
    logic       key_press;
    logic [3:0] key_value;
    logic       key_held;

    logic [11:0] pressed = '0;
    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] value;
        int         lo;
        int         hi;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_press = 1'b0;

    keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .CLOCK_50  (clk),
        .rst_n     (rst_n),
        .scan_en   (scan_en),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_press (key_press),
        .key_value (key_value),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Key index = row*3 + col; a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[r*3+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    always @(negedge clk) begin
        if (rst_n && key_press) begin
            checks++;
            if (prev_press) begin
                errors++;
                $display("FAIL back_to_back: key_press high again at cycle %0d, required single-cycle strobe", cyc);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_press: got key_value=%0d at cycle %0d, required no strobe", key_value, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (key_value !== mon_e.value || cyc < mon_e.lo || cyc > mon_e.hi || key_held !== 1'b1) begin
                    errors++;
                    $display("FAIL press: got value=%0d held=%0b at cycle %0d, required value=%0d held=1 in [%0d,%0d]",
                             key_value, key_held, cyc, mon_e.value, mon_e.lo, mon_e.hi);
                end else begin
                    $display("press: value=%0d at cycle %0d (window %0d..%0d)", key_value, cyc, mon_e.lo, mon_e.hi);
                end
            end
        end
        prev_press = rst_n && key_press;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("check %s: %0h", name, act);
        end
    endtask

    task automatic expect_press(input logic [3:0] v, input int lo_off, input int hi_off);
        exp_t e;
        e.value = v;
        e.lo    = cyc + lo_off;
        e.hi    = cyc + hi_off;
        exp_q.push_back(e);
    endtask

    task automatic wait_held(input logic lvl, input int budget, input string name);
        int n = 0;
        while (key_held !== lvl && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (key_held !== lvl) begin
            errors++;
            $display("FAIL %s: key_held=%0b after %0d cycles, required %0b", name, key_held, budget, lvl);
        end else begin
            $display("check %s: key_held=%0b after %0d cycles", name, lvl, n);
        end
    endtask

    task automatic wait_row_entry(input logic [3:0] pat, input int budget, input string name);
        logic [3:0] last;
        logic       found;
        int         n;
        last  = row_n;
        found = 1'b0;
        n     = 0;
        while (!found && n < budget) begin
            tick(1);
            n++;
            if (row_n == pat && last != pat) found = 1'b1;
            last = row_n;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: row_n never entered %b within %0d cycles", name, pat, budget);
        end
    endtask

    initial begin
        logic [3:0] exp_row;
        tick(3);
        check("reset_row_n", {28'd0, row_n}, 32'hF);
        check("reset_key_press", {31'd0, key_press}, 32'd0);
        check("reset_key_value", {28'd0, key_value}, 32'd0);
        check("reset_key_held", {31'd0, key_held}, 32'd0);

        // Idle scanning: each row low for SD cycles in turn.
        rst_n   = 1'b1;
        scan_en = 1'b1;
        for (int k = 0; k < 8 * SD; k++) begin
            tick(1);
            if ((k % SD) == 0 || (k % SD) == SD - 1) begin
                exp_row = 4'b0001 << ((k / SD) % 4);
                exp_row = ~exp_row;
                check("scan_row_n", {28'd0, row_n}, {28'd0, exp_row});
            end
        end
        check("idle_key_value", {28'd0, key_value}, 32'd0);

        // Key 5 press and release.
        pressed[4] = 1'b1;
        expect_press(4'd5, 64, 130);
        wait_held(1'b1, 200, "k5_held");
        check("k5_value", {28'd0, key_value}, 32'd5);
        pressed = '0;
        tick(60);
        check("k5_still_held", {31'd0, key_held}, 32'd1);
        wait_held(1'b0, 80, "k5_release");

        // '#' with a short glitch before the steady closure.
        pressed[11] = 1'b1;
        tick(40);
        pressed = '0;
        tick(64);
        pressed[11] = 1'b1;
        expect_press(4'd11, 64, 130);
        wait_held(1'b1, 200, "hash_held");
        check("hash_value", {28'd0, key_value}, 32'd11);
        pressed = '0;
        wait_held(1'b0, 200, "hash_release");

        // '1' and '9' together: never accepted until '9' lets go.
        pressed[0] = 1'b1;
        pressed[8] = 1'b1;
        tick(6 * 4 * SD);
        check("multi_not_held", {31'd0, key_held}, 32'd0);
        check("multi_value_kept", {28'd0, key_value}, 32'd11);
        pressed[8] = 1'b0;
        expect_press(4'd1, 64, 130);
        wait_held(1'b1, 200, "k1_held");
        check("k1_value", {28'd0, key_value}, 32'd1);
        pressed = '0;
        wait_held(1'b0, 200, "k1_release");

        // Key 0, then scan_en dropped and restored.
        pressed[10] = 1'b1;
        expect_press(4'd0, 64, 130);
        wait_held(1'b1, 200, "k0_held");
        scan_en = 1'b0;
        tick(1);
        check("dis_row_n", {28'd0, row_n}, 32'hF);
        check("dis_key_held", {31'd0, key_held}, 32'd0);
        check("dis_key_value", {28'd0, key_value}, 32'd0);
        tick(9);
        check("dis_row_n_late", {28'd0, row_n}, 32'hF);
        scan_en = 1'b1;
        expect_press(4'd0, 96, 138);
        tick(1);
        check("reen_row_n", {28'd0, row_n}, 32'hE);
        wait_held(1'b1, 200, "k0_reheld");
        pressed = '0;
        wait_held(1'b0, 200, "k0_release");

        // Key 8 for two frames, then reset inside row 2 of the third frame.
        wait_row_entry(4'b1110, 40, "frame_align");
        pressed[7] = 1'b1;
        wait_row_entry(4'b1011, 40, "row2_a");
        wait_row_entry(4'b1011, 40, "row2_b");
        wait_row_entry(4'b1011, 40, "row2_c");
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_row_n", {28'd0, row_n}, 32'hF);
        check("rst_key_press", {31'd0, key_press}, 32'd0);
        check("rst_key_held", {31'd0, key_held}, 32'd0);
        check("rst_key_value", {28'd0, key_value}, 32'd0);
        tick(3);
        rst_n = 1'b1;
        expect_press(4'd8, 96, 138);
        wait_held(1'b1, 200, "k8_held");
        check("k8_value", {28'd0, key_value}, 32'd8);
        pressed = '0;
        wait_held(1'b0, 200, "k8_release");

        tick(40);
        check("presses_outstanding", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
